// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

   localparam int unsigned DEF_CLK_FREQ = 12_000_000;
   localparam int unsigned DEF_WIDTH    = 24;
   localparam int unsigned DEF_CHANNELS = 4;

   typedef enum logic [1:0] {
      MODE_STOP,
      MODE_RUN,
      MODE_HOLD
   } chan_mode_e;

   // Half-period count for a requested output frequency.
   function automatic int unsigned hz_to_half(input int unsigned freq);
      return DEF_CLK_FREQ / freq / 2;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active half-period, free-running counter, and a
// single-entry shadow that is applied on a half-period boundary.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_half,
   input  logic             wr_oneshot,
   output logic             pending,
   output logic             div_clk,
   output logic             div_pulse,
   output logic             done
);

   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] sh_half;
   logic             oneshot;
   logic             sh_oneshot;
   chan_mode_e       mode;
   logic             boundary;
   logic             fall;
   logic             apply;

   always_comb begin
      mode = MODE_STOP;
      if (half != '0) mode = enable ? MODE_RUN : MODE_HOLD;
      boundary = (mode == MODE_RUN) && (cnt == half - WIDTH'(1));
      fall     = boundary && div_clk;
      apply    = pending && (boundary || (mode != MODE_RUN));
   end

   // Later assignments win: a shadow apply overrides the one-shot stop, and a
   // new write clears done even if a one-shot completes in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half       <= '0;
         cnt        <= '0;
         sh_half    <= '0;
         oneshot    <= 1'b0;
         sh_oneshot <= 1'b0;
         pending    <= 1'b0;
         div_clk    <= 1'b0;
         div_pulse  <= 1'b0;
         done       <= 1'b0;
      end else begin
         div_pulse <= fall;
         case (mode)
            MODE_STOP: begin
               cnt     <= '0;
               div_clk <= 1'b0;
            end
            MODE_RUN: begin
               if (boundary) begin
                  cnt     <= '0;
                  div_clk <= ~div_clk;
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
            default: ;
         endcase
         if (fall && oneshot) begin
            half <= '0;
            done <= 1'b1;
         end
         if (apply) begin
            half    <= sh_half;
            oneshot <= sh_oneshot;
            cnt     <= '0;
            pending <= 1'b0;
         end
         if (wr) begin
            sh_half    <= wr_half;
            sh_oneshot <= wr_oneshot;
            pending    <= 1'b1;
            done       <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock-divider channels sharing one configuration
// write port with a per-channel pending-shadow handshake.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] enable,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [WIDTH-1:0]    cfg_half,
   input  logic                cfg_oneshot,
   output logic [CHANNELS-1:0] dividedClk,
   output logic [CHANNELS-1:0] dividedPulse,
   output logic [CHANNELS-1:0] done
);

   logic [CHANNELS-1:0] pending;
   logic [(1<<CW)-1:0]  pending_pad;

   if (CLK_FREQ < 2 || CHANNELS < 1 || CHANNELS > 16) begin : g_param_check
      $error("clk_div_multi: unsupported CLK_FREQ or CHANNELS");
   end

   // Unused channel indices read as not-pending, so writes to them handshake
   // and are then dropped because no channel decodes them.
   always_comb begin
      pending_pad                = '0;
      pending_pad[CHANNELS-1:0]  = pending;
   end

   assign cfg_ready = ~pending_pad[cfg_chan];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      clk_div_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .enable     (enable[i]),
         .wr         (cfg_valid && cfg_ready && (cfg_chan == CW'(i))),
         .wr_half    (cfg_half),
         .wr_oneshot (cfg_oneshot),
         .pending    (pending[i]),
         .div_clk    (dividedClk[i]),
         .div_pulse  (dividedPulse[i]),
         .done       (done[i])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random
// configuration traffic against a half-period-countdown reference model.
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int unsigned CH  = 4;
   localparam int unsigned W   = 24;
   localparam int unsigned CWT = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [CH-1:0]  enable;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CWT-1:0] cfg_chan;
   logic [W-1:0]   cfg_half;
   logic           cfg_oneshot;
   logic [CH-1:0]  dividedClk;
   logic [CH-1:0]  dividedPulse;
   logic [CH-1:0]  done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   clk_div_multi #(
      .CLK_FREQ (DEF_CLK_FREQ),
      .CHANNELS (CH),
      .WIDTH    (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_chan     (cfg_chan),
      .cfg_half     (cfg_half),
      .cfg_oneshot  (cfg_oneshot),
      .dividedClk   (dividedClk),
      .dividedPulse (dividedPulse),
      .done         (done)
   );

   // Reference model: each channel counts down the cycles left in its
   // current half-period and flips its level when the count runs out.
   int   m_h[CH];
   int   m_left[CH];
   int   m_sh[CH];
   logic m_lvl[CH];
   logic m_pulse[CH];
   logic m_done[CH];
   logic m_os[CH];
   logic m_sos[CH];
   logic m_pend[CH];
   logic m_run[CH];
   logic m_edge[CH];
   logic m_fall[CH];
   logic m_wr[CH];
   logic m_apply[CH];
   logic [CH-1:0] m_clk_v, m_pulse_v, m_done_v;
   logic          m_ready;

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         m_run[i]     = (m_h[i] != 0) && enable[i];
         m_edge[i]    = m_run[i] && (m_left[i] == 1);
         m_fall[i]    = m_edge[i] && m_lvl[i];
         m_wr[i]      = cfg_valid && (int'(cfg_chan) == i) && !m_pend[i];
         m_apply[i]   = m_pend[i] && (m_edge[i] || !m_run[i]);
         m_clk_v[i]   = m_lvl[i];
         m_pulse_v[i] = m_pulse[i];
         m_done_v[i]  = m_done[i];
      end
      m_ready = !m_pend[int'(cfg_chan)];
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_h[i] <= 0; m_left[i] <= 0; m_sh[i] <= 0;
            m_lvl[i] <= 1'b0; m_pulse[i] <= 1'b0; m_done[i] <= 1'b0;
            m_os[i] <= 1'b0; m_sos[i] <= 1'b0; m_pend[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            m_pulse[i] <= m_fall[i];
            if (m_h[i] == 0) begin
               m_lvl[i]  <= 1'b0;
               m_left[i] <= 0;
            end else if (enable[i]) begin
               if (m_left[i] == 1) begin
                  m_lvl[i]  <= !m_lvl[i];
                  m_left[i] <= m_h[i];
               end else begin
                  m_left[i] <= m_left[i] - 1;
               end
            end
            if (m_fall[i] && m_os[i]) begin
               m_h[i]    <= 0;
               m_done[i] <= 1'b1;
            end
            if (m_apply[i]) begin
               m_h[i]    <= m_sh[i];
               m_os[i]   <= m_sos[i];
               m_left[i] <= m_sh[i];
               m_pend[i] <= 1'b0;
            end
            if (m_wr[i]) begin
               m_sh[i]   <= int'(cfg_half);
               m_sos[i]  <= cfg_oneshot;
               m_pend[i] <= 1'b1;
               m_done[i] <= 1'b0;
            end
         end
      end
   end

   // Stimulus driver: holds a write until it is handshaken; reports stalls.
   task automatic do_write(input int ch, input int half, input bit os, output int stalls);
      bit acc;
      acc    = 1'b0;
      stalls = 0;
      cfg_valid   = 1'b1;
      cfg_chan    = CWT'(ch);
      cfg_half    = W'(half);
      cfg_oneshot = os;
      for (int n = 0; n < 64 && !acc; n++) begin
         @(negedge clk);
         acc = cfg_ready;
         @(posedge clk);
         #1;
         if (!acc) stalls++;
      end
      cfg_valid = 1'b0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL write_timeout ch%0d: cfg_ready got 0 for 64 cycles, want 1", ch);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = '0; cfg_valid = 1'b0; cfg_chan = '0;
      cfg_half = '0; cfg_oneshot = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({dividedClk, dividedPulse, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 0", {dividedClk, dividedPulse, done});
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (cfg_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", cfg_ready);
      end
   endtask

   task automatic test_free_run();
      int st;
      bit exp_clk, exp_pulse;
      enable = '1;
      do_write(0, 3, 1'b0, st);
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk);
         #1;
         exp_clk   = (((k - 1) / 3) % 2) == 1;
         exp_pulse = (k >= 7) && (((k - 1) % 6) == 0);
         vectors++;
         if ({dividedClk[0], dividedPulse[0]} !== {exp_clk, exp_pulse}) begin
            miscompares++;
            $display("FAIL free_run k=%0d: clk/pulse got %b%b want %b%b",
                     k, dividedClk[0], dividedPulse[0], exp_clk, exp_pulse);
         end
         vectors++;
         if ({dividedClk, dividedPulse, done, cfg_ready} !== {m_clk_v, m_pulse_v, m_done_v, m_ready}) begin
            miscompares++;
            $display("FAIL free_run_model k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done, cfg_ready}, {m_clk_v, m_pulse_v, m_done_v, m_ready});
         end
      end
   endtask

   task automatic test_reconfig();
      int st;
      do_write(1, 4, 1'b0, st);
      repeat (6) @(posedge clk);
      #1;
      do_write(1, 2, 1'b0, st);
      vectors++;
      if (cfg_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reconfig_pending_ready: got %b want 0", cfg_ready);
      end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk, dividedPulse, done, cfg_ready} !== {m_clk_v, m_pulse_v, m_done_v, m_ready}) begin
            miscompares++;
            $display("FAIL reconfig_model k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done, cfg_ready}, {m_clk_v, m_pulse_v, m_done_v, m_ready});
         end
      end
   endtask

   task automatic test_oneshot();
      int st, pulses, highs;
      pulses = 0;
      highs  = 0;
      do_write(2, 5, 1'b1, st);
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (dividedPulse[2]) pulses++;
         if (dividedClk[2]) highs++;
         vectors++;
         if ({dividedClk, dividedPulse, done} !== {m_clk_v, m_pulse_v, m_done_v}) begin
            miscompares++;
            $display("FAIL oneshot_model k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done}, {m_clk_v, m_pulse_v, m_done_v});
         end
      end
      vectors++;
      if ({pulses, highs} !== {32'd1, 32'd5}) begin
         miscompares++;
         $display("FAIL oneshot_counts: pulses/highs got %0d/%0d want 1/5", pulses, highs);
      end
      vectors++;
      if ({done[2], dividedClk[2]} !== 2'b10) begin
         miscompares++;
         $display("FAIL oneshot_final: done2/clk2 got %b%b want 10", done[2], dividedClk[2]);
      end
   endtask

   task automatic test_enable_freeze();
      int st;
      logic held;
      do_write(3, 2, 1'b0, st);
      repeat (5) @(posedge clk);
      #1;
      held = m_clk_v[3];
      enable[3] = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk[3], dividedPulse[3]} !== {held, 1'b0}) begin
            miscompares++;
            $display("FAIL freeze k=%0d: clk3/pulse3 got %b%b want %b0",
                     k, dividedClk[3], dividedPulse[3], held);
         end
      end
      enable[3] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk, dividedPulse, done} !== {m_clk_v, m_pulse_v, m_done_v}) begin
            miscompares++;
            $display("FAIL freeze_resume k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done}, {m_clk_v, m_pulse_v, m_done_v});
         end
      end
   endtask

   task automatic test_back_to_back();
      int st1, st2;
      enable = '1;
      do_write(0, 5, 1'b0, st1);
      do_write(0, 2, 1'b0, st2);
      vectors++;
      if (st1 != 0 || st2 < 1 || st2 > 3) begin
         miscompares++;
         $display("FAIL back_to_back_stall: stalls got %0d/%0d want 0/1..3", st1, st2);
      end
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk, dividedPulse, done, cfg_ready} !== {m_clk_v, m_pulse_v, m_done_v, m_ready}) begin
            miscompares++;
            $display("FAIL back_to_back_model k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done, cfg_ready}, {m_clk_v, m_pulse_v, m_done_v, m_ready});
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < CH; i++) enable[i] = ($urandom_range(0, 7) != 0);
         cfg_valid   = ($urandom_range(0, 2) == 0);
         cfg_chan    = CWT'($urandom_range(0, CH - 1));
         cfg_half    = W'($urandom_range(0, 5));
         cfg_oneshot = ($urandom_range(0, 3) == 0);
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk, dividedPulse, done, cfg_ready} !== {m_clk_v, m_pulse_v, m_done_v, m_ready}) begin
            miscompares++;
            $display("FAIL random_model k=%0d: got %b want %b", k,
                     {dividedClk, dividedPulse, done, cfg_ready}, {m_clk_v, m_pulse_v, m_done_v, m_ready});
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int st;
      enable = '1;
      for (int i = 0; i < CH; i++) do_write(i, 3, 1'b0, st);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({dividedClk, dividedPulse, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_async: got %b want 0", {dividedClk, dividedPulse, done});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < CH; i++) begin
         cfg_chan = CWT'(i);
         #1;
         vectors++;
         if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_ready ch%0d: got %b want 1", i, cfg_ready);
         end
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({dividedClk, dividedPulse, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %b want 0", {dividedClk, dividedPulse, done});
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_reconfig();
      test_oneshot();
      test_enable_freeze();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
